// File: rtl/mlp_feeder_pkg.sv
// Shared constants for the MLP feature feeder: default frame geometry and FSM state codes.
package mlp_feeder_pkg;

   localparam int N_FEAT = 9;
   localparam int FEAT_W = 4;
   localparam int CLS_W  = 2;
   localparam int INP_W  = N_FEAT * FEAT_W;

   // FSM state encoding (plain constants so older tools can consume them too)
   localparam logic [1:0] ST_LOAD   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_RESULT = 2'd2;

endpackage

// File: rtl/feeder_settle_timer.sv
// Loadable down-counter that gives the combinational classifier time to settle.
// Counts down while enabled, saturates at zero, and flags zero combinationally.
module feeder_settle_timer #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load wins over decrement; never wrap below zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mlp_feature_feeder.sv
// Collects a frame of quantized features from a valid/ready stream into a packed
// vector for an external combinational classifier, waits a fixed settle time,
// captures the class and offers it on a valid/ready result port.
module mlp_feature_feeder #(
   parameter int N_FEAT = mlp_feeder_pkg::N_FEAT,
   parameter int FEAT_W = mlp_feeder_pkg::FEAT_W,
   parameter int CLS_W  = mlp_feeder_pkg::CLS_W,
   parameter int SETTLE = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [FEAT_W-1:0]        s_data,
   input  logic                     s_last,
   output logic [N_FEAT*FEAT_W-1:0] mlp_inp,
   input  logic [CLS_W-1:0]         mlp_out,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [CLS_W-1:0]         m_class,
   output logic                     err,
   output logic [15:0]              frame_cnt
);

   import mlp_feeder_pkg::*;

   localparam int K_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [K_W-1:0]   K_LAST    = K_W'(N_FEAT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

   logic [1:0]       state_q, state_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [CLS_W-1:0] cls_q, cls_d;
   logic             err_q, err_d;
   logic [15:0]      cnt_q, cnt_d;

   logic s_hs;
   logic m_hs;
   logic last_pos;
   logic frame_done;
   logic frame_err;
   logic tmr_zero;
   logic settle_done;

   assign s_ready = (state_q == ST_LOAD);
   assign m_valid = (state_q == ST_RESULT);

   assign s_hs        = s_valid && s_ready;
   assign m_hs        = m_valid && m_ready;
   assign last_pos    = (k_q == K_LAST);
   assign frame_done  = s_hs && s_last && last_pos;
   // s_last must coincide exactly with the final slot; anything else drops the frame
   assign frame_err   = s_hs && (s_last != last_pos);
   assign settle_done = (state_q == ST_WAIT) && tmr_zero;

   feeder_settle_timer #(
      .CNT_W (CNT_W)
   ) u_settle (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (frame_done),
      .load_val_i (SETTLE_LD),
      .dec_i      (state_q == ST_WAIT),
      .zero_o     (tmr_zero)
   );

   // FSM next state: LOAD -> WAIT on a clean frame end, WAIT -> RESULT once settled,
   // RESULT -> LOAD when the sink takes the result
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:   if (frame_done)  state_d = ST_WAIT;
         ST_WAIT:   if (tmr_zero)    state_d = ST_RESULT;
         ST_RESULT: if (m_ready)     state_d = ST_LOAD;
         default:                    state_d = ST_LOAD;
      endcase
   end

   // Feature index, class capture, error pulse and delivered-frame counter next values
   always_comb begin
      k_d = k_q;
      if (s_hs) begin
         // both a proper frame end and a framing error restart at slot 0
         if (s_last || last_pos) begin
            k_d = '0;
         end else begin
            k_d = k_q + 1'b1;
         end
      end
      cls_d = settle_done ? mlp_out : cls_q;
      err_d = frame_err;
      cnt_d = m_hs ? (cnt_q + 16'd1) : cnt_q;
   end

   // Control and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         k_q     <= '0;
         cls_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cls_q   <= cls_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // One feature slot per index; only the addressed slot is written, so slots
   // filled before a dropped frame keep their value
   for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_slot
      localparam logic [K_W-1:0] SLOT_IDX = K_W'(gi);
      logic [FEAT_W-1:0] slot_q;

      // Slot register, written on a handshake at its index
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot_q <= '0;
         end else if (s_hs && (k_q == SLOT_IDX)) begin
            slot_q <= s_data;
         end
      end

      assign mlp_inp[gi*FEAT_W +: FEAT_W] = slot_q;
   end

   assign m_class   = cls_q;
   assign err       = err_q;
   assign frame_cnt = cnt_q;

endmodule

// File: doc/mlp_feature_feeder.md
MLP_FEATURE_FEEDER -- requirements
Module: mlp_feature_feeder

Interface
REQ-001 The block SHALL have the parameter N_FEAT, default 9: the number of features per frame.
REQ-002 The block SHALL have the parameter FEAT_W, default 4: the width of one quantized feature.
REQ-003 The block SHALL have the parameter CLS_W, default 2: the width of the classifier class index.
REQ-004 The block SHALL have the parameter SETTLE, default 2, legal range >=1: the number of cycles allowed for the combinational classifier to settle.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have the port s_valid, input, 1 bit: the feature source has a feature.
REQ-008 The block SHALL have the port s_ready, output, 1 bit: the block accepts a feature.
REQ-009 The block SHALL have the port s_data, input, FEAT_W bits: the feature value.
REQ-010 The block SHALL have the port s_last, input, 1 bit: marks the final feature of a frame.
REQ-011 The block SHALL have the port mlp_inp, output, N_FEAT*FEAT_W bits: the packed feature vector driven to the classifier input.
REQ-012 The block SHALL have the port mlp_out, input, CLS_W bits: the class index returned by the classifier.
REQ-013 The block SHALL have the port m_valid, output, 1 bit: a result is available.
REQ-014 The block SHALL have the port m_ready, input, 1 bit: the sink accepts the result.
REQ-015 The block SHALL have the port m_class, output, CLS_W bits: the captured class.
REQ-016 The block SHALL have the port err, output, 1 bit: a one-cycle pulse indicating a framing error.
REQ-017 The block SHALL have the port frame_cnt, output, 16 bits: the count of delivered results.

Function
REQ-018 The block SHALL implement an FSM with states LOAD, WAIT and RESULT; s_ready SHALL be 1 only in LOAD, and m_valid SHALL be 1 only in RESULT.
REQ-019 A feature handshake (s_valid && s_ready) at index k SHALL write s_data into mlp_inp[k*FEAT_W +: FEAT_W] and increment k; feature 0 occupies the LSBs.
REQ-020 A handshake with k==N_FEAT-1 and s_last==1 SHALL move the FSM to WAIT, load the settle counter with SETTLE-1, and reset k to 0.
REQ-021 Framing error: a handshake where s_last differs from (k==N_FEAT-1) SHALL pulse err for exactly one cycle, drop the frame (k=0), and keep the FSM in LOAD; mlp_inp nibbles already written SHALL NOT be cleared.
REQ-022 In WAIT, the settle counter SHALL decrement each cycle; at count 0 the block SHALL register mlp_out into m_class and move to RESULT.
REQ-023 Latency: m_valid SHALL rise exactly SETTLE cycles after the clock edge that accepted the last feature.
REQ-024 In RESULT, m_valid and m_class SHALL hold stable until m_ready==1; on the m_valid && m_ready handshake the FSM SHALL return to LOAD and frame_cnt SHALL increment, wrapping from 16'hFFFF to 0.
REQ-025 mlp_inp SHALL remain constant throughout WAIT and RESULT.
REQ-026 s_valid in WAIT or RESULT SHALL be ignored, because s_ready is 0.
REQ-027 An m_ready pulse outside RESULT SHALL have no effect.

Reset
REQ-028 While rst_n==0, the block SHALL hold the FSM in LOAD with k=0, settle counter=0, mlp_inp=0, m_class=0, err=0 and frame_cnt=0; consequently s_ready=1 and m_valid=0.
REQ-029 Reset asserted in any state SHALL abort the frame in flight immediately; no m_valid SHALL follow for that frame.
REQ-030 After rst_n deasserts, the block SHALL accept a feature on the first rising edge.

Structure
REQ-031 The package mlp_feeder_pkg SHALL hold N_FEAT, FEAT_W, CLS_W, the derived INP_W=N_FEAT*FEAT_W, and the FSM state enumeration.
REQ-032 The settle counter SHALL be a sub-module feeder_settle_timer, with load, count-down and zero-flag functions.
REQ-033 The classifier SHALL NOT be instantiated inside this block; the bench SHALL connect mlp_inp and mlp_out to it.

Verification
REQ-034 The bench SHALL cover a nominal frame: features 1,2,...,9 with s_last on the 9th, and mlp_out=2'b01 -> mlp_inp=36'h987654321, m_valid high 2 cycles after the 9th handshake, m_class=2'b01, frame_cnt=1 after the result handshake.
REQ-035 The bench SHALL cover back-pressure: m_ready held 0 for 5 cycles in RESULT while mlp_out toggles -> m_valid stays 1, m_class is unchanged, s_ready stays 0, and there is exactly one frame_cnt increment.
REQ-036 The bench SHALL cover an early s_last on the 4th feature -> err=1 for one cycle, no m_valid, and a following complete frame yields a correct result.
REQ-037 The bench SHALL cover a missing s_last on the 9th feature -> err pulse, FSM stays in LOAD, k=0.
REQ-038 The bench SHALL cover rst_n dropped during WAIT -> m_valid never asserts, mlp_inp=0, s_ready=1 after release.
REQ-039 The bench SHALL cover a gapped source: s_valid deasserted randomly between features -> mlp_inp and the result are identical to the nominal case.
